// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the dmem responder: load/store sizes, FSM states,
// and the size/offset decode helpers used on both the store and load paths.
package dmem_responder_pkg;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  // Reserved size 2'b11 counts as misaligned so it folds into the error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LS_WORD: misaligned = (off != 2'b00);
      LS_HALF: misaligned = off[0];
      LS_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LS_WORD: lane_mask = 4'b1111;
      LS_HALF: lane_mask = 4'b0011 << off;
      LS_BYTE: lane_mask = 4'b0001 << off;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_ldext.sv
// Load lane select plus sign/zero extension; purely combinational.
module dmem_ldext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        lu,
  output logic [31:0] result
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel = raw[{off, 3'b000} +: 8];
    hsel = raw[{off[1], 4'b0000} +: 16];
    case (size)
      LS_BYTE: result = lu ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      LS_HALF: result = lu ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the xgriscv load/store port: byte-lane stores,
// 1-cycle registered loads, error flagging and a post-reset memory clear.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [3:0]      amp,
  input  logic [31:0]     daddr,
  input  logic [XLEN-1:0] writedata,
  input  logic [1:0]      lwhb,
  input  logic [1:0]      swhb,
  input  logic            lu,
  output logic [XLEN-1:0] readdata,
  output logic            rvalid,
  output logic            err,
  output logic            busy
);

  logic [XLEN-1:0] mem [2**ADDR_W];

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              oor, ld_bad, st_bad;
  logic [3:0]        lanes;
  logic [XLEN-1:0]   wrep;

  logic [XLEN-1:0] cap_raw;
  logic [1:0]      cap_off, cap_size;
  logic            cap_lu, cap_bad;
  logic [XLEN-1:0] ext;

  assign idx    = daddr[ADDR_W+1:2];
  assign off    = daddr[1:0];
  assign oor    = (daddr[31:ADDR_W+2] != '0);
  assign ld_bad = oor | misaligned(lwhb, off);
  assign st_bad = oor | misaligned(swhb, off);
  assign lanes  = lane_mask(swhb, off);

  always_comb begin
    case (swhb)
      LS_BYTE: wrep = {4{writedata[7:0]}};
      LS_HALF: wrep = {2{writedata[15:0]}};
      default: wrep = writedata;
    endcase
  end

  // Storage has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (memwrite && !st_bad) begin
        for (int i = 0; i < 4; i++)
          if (lanes[i]) mem[idx][i*8 +: 8] <= wrep[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      ptr      <= '0;
      busy     <= 1'b1;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      cap_raw  <= '0;
      cap_off  <= 2'b00;
      cap_size <= LS_WORD;
      cap_lu   <= 1'b0;
      cap_bad  <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          rvalid <= memread;
          err    <= (memread && ld_bad) ||
                    (memwrite && (st_bad || amp != lanes));
          // Read-first: mem[idx] here is the pre-store contents.
          if (memread) begin
            cap_raw  <= mem[idx];
            cap_off  <= off;
            cap_size <= lwhb;
            cap_lu   <= lu;
            cap_bad  <= ld_bad;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  dmem_ldext u_ldext (
    .raw    (cap_raw),
    .off    (cap_off),
    .size   (cap_size),
    .lu     (cap_lu),
    .result (ext)
  );

  // Capture registers only move on a load, so readdata holds between loads.
  assign readdata = cap_bad ? '0 : ext;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset/clear
// sequences, and randomized traffic against a byte-array reference model.
module tb_dmem_responder;

  localparam int AW    = 4;
  localparam int NBYTE = 4 * (2**AW);

  logic        clk = 1'b0;
  logic        reset, memread, memwrite, lu;
  logic [3:0]  amp;
  logic [31:0] daddr, writedata, readdata;
  logic [1:0]  lwhb, swhb;
  logic        rvalid, err, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mbytes [NBYTE];
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .amp(amp), .daddr(daddr), .writedata(writedata), .lwhb(lwhb),
    .swhb(swhb), .lu(lu), .readdata(readdata), .rvalid(rvalid),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic        rd, wr;
    logic [3:0]  amp;
    logic [31:0] addr, wd;
    logic [1:0]  lsz, ssz;
    logic        lu;
    logic        erv, eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic bad(input logic [1:0] sz, input logic [31:0] a);
    if (a >= NBYTE || sz == 2'b11) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a, input logic u);
    int n = nbytes(sz);
    logic [31:0] v = 0;
    for (int j = 0; j < n; j++) v = v | (32'(mbytes[a + j]) << (8 * j));
    if (!u && n < 4 && ((v >> (8 * n - 1)) & 32'h1) != 0)
      v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n = nbytes(sz);
    for (int j = 0; j < n; j++) mbytes[a + j] = 8'(d >> (8 * j));
  endtask

  task automatic model_clear();
    for (int j = 0; j < NBYTE; j++) mbytes[j] = 8'h00;
    exp_rd = 0;
  endtask

  // One request per clock; outputs sampled 1ns after the edge that took it.
  task automatic drive(input logic rd, input logic wr, input logic [3:0] a_mp,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] ls, input logic [1:0] ss, input logic u);
    memread = rd; memwrite = wr; amp = a_mp; daddr = a; writedata = d;
    lwhb = ls; swhb = ss; lu = u;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  function automatic vec_t v(input logic rd, input logic wr, input logic [3:0] a_mp,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] ls, input logic [1:0] ss, input logic u,
                             input logic erv, input logic eerr, input logic [31:0] erd);
    vec_t r;
    r.rd = rd; r.wr = wr; r.amp = a_mp; r.addr = a; r.wd = d; r.lsz = ls;
    r.ssz = ss; r.lu = u; r.erv = erv; r.eerr = eerr; r.erd = erd;
    return r;
  endfunction

  initial begin
    int n;
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; amp = 4'h0; daddr = 0;
    writedata = 0; lwhb = 2'b00; swhb = 2'b00; lu = 1'b0;
    model_clear();

    // Reset and clear sweep
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", 32'(busy), 1);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_readdata", readdata, 0);
    drive(1, 0, 4'h0, 32'h0, 0, 2'b00, 2'b00, 0);
    check("busy_rd_rvalid", 32'(rvalid), 0);
    drive(0, 1, 4'hF, 32'h0, 32'hFFFF_FFFF, 2'b00, 2'b00, 0);
    check("busy_wr_err", 32'(err), 0);
    count_busy(n);
    check("clear_len", 32'(n + 2), 16);
    drive(1, 0, 4'h0, 32'h0, 0, 2'b00, 2'b00, 0);
    check("post_clear_rvalid", 32'(rvalid), 1);
    check("post_clear_data", readdata, 0);

    // Directed table
    tbl.push_back(v(0,1,4'hF,32'h8,32'hDEADBEEF,2'b00,2'b00,0, 0,0,0));
    tbl.push_back(v(1,0,4'h0,32'h8,0,2'b00,2'b00,0, 1,0,32'hDEADBEEF));
    tbl.push_back(v(0,1,4'h2,32'h5,32'h80,2'b00,2'b10,0, 0,0,0));
    tbl.push_back(v(1,0,4'h0,32'h5,0,2'b10,2'b00,0, 1,0,32'hFFFFFF80));
    tbl.push_back(v(1,0,4'h0,32'h5,0,2'b10,2'b00,1, 1,0,32'h00000080));
    tbl.push_back(v(1,0,4'h0,32'h4,0,2'b00,2'b00,0, 1,0,32'h00008000));
    tbl.push_back(v(0,1,4'hC,32'h6,32'h8001,2'b00,2'b01,0, 0,0,0));
    tbl.push_back(v(1,0,4'h0,32'h6,0,2'b01,2'b00,0, 1,0,32'hFFFF8001));
    tbl.push_back(v(1,0,4'h0,32'h6,0,2'b01,2'b00,1, 1,0,32'h00008001));
    tbl.push_back(v(1,0,4'h0,32'h4,0,2'b00,2'b00,0, 1,0,32'h80018000));
    tbl.push_back(v(0,1,4'hF,32'h0,32'h11111111,2'b00,2'b00,0, 0,0,0));
    tbl.push_back(v(1,1,4'hF,32'h0,32'h22222222,2'b00,2'b00,0, 1,0,32'h11111111));
    tbl.push_back(v(1,0,4'h0,32'h0,0,2'b00,2'b00,0, 1,0,32'h22222222));
    tbl.push_back(v(1,0,4'h0,32'h2,0,2'b00,2'b00,0, 1,1,32'h0));
    tbl.push_back(v(0,1,4'h8,32'h3,32'h1234,2'b00,2'b01,0, 0,1,0));
    tbl.push_back(v(1,0,4'h0,32'h0,0,2'b00,2'b00,0, 1,0,32'h22222222));
    tbl.push_back(v(0,1,4'h1,32'h1,32'h55,2'b00,2'b10,0, 0,1,0));
    tbl.push_back(v(1,0,4'h0,32'h0,0,2'b00,2'b00,0, 1,0,32'h22225522));
    tbl.push_back(v(1,0,4'h0,32'h100,0,2'b00,2'b00,0, 1,1,32'h0));
    tbl.push_back(v(0,1,4'hF,32'h100,32'h5A5A5A5A,2'b00,2'b00,0, 0,1,0));
    tbl.push_back(v(1,0,4'h0,32'hC,0,2'b11,2'b00,1, 1,1,32'h0));
    tbl.push_back(v(1,1,4'hF,32'h2,32'h77777777,2'b00,2'b00,0, 1,1,32'h0));
    tbl.push_back(v(0,0,4'h0,32'h0,0,2'b00,2'b00,0, 0,0,0));
    tbl.push_back(v(1,0,4'h0,32'h0,0,2'b00,2'b00,0, 1,0,32'h22225522));

    foreach (tbl[i]) begin
      vec_t t = tbl[i];
      if (t.erv) exp_rd = t.erd;
      drive(t.rd, t.wr, t.amp, t.addr, t.wd, t.lsz, t.ssz, t.lu);
      if (t.wr && !bad(t.ssz, t.addr)) model_store(t.ssz, t.addr, t.wd);
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(t.erv));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(t.eerr));
      check($sformatf("tbl%0d_readdata", i), readdata, exp_rd);
    end

    // Randomized traffic vs. byte-array model
    for (int i = 0; i < 400; i++) begin
      logic rd, wr, u, erv, eerr;
      logic [1:0] ls, ss;
      logic [31:0] a, d;
      logic [3:0] am;
      int r;
      rd = 1'($urandom % 2);
      wr = 1'($urandom % 3 == 0);
      r = int'($urandom % 8); ls = (r < 7) ? 2'(r % 3) : 2'b11;
      r = int'($urandom % 8); ss = (r < 7) ? 2'(r % 3) : 2'b11;
      a = $urandom_range(0, NBYTE - 1);
      if ($urandom % 4 != 0) a = a & ~32'(nbytes(wr ? ss : ls) - 1);
      if ($urandom % 16 == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      d = $urandom;
      u = 1'($urandom % 2);
      am = ($urandom % 8 == 0) ? 4'($urandom) : exp_mask(ss, a);
      erv = rd;
      eerr = (rd && bad(ls, a)) || (wr && (bad(ss, a) || am != exp_mask(ss, a)));
      if (rd) exp_rd = bad(ls, a) ? 32'h0 : model_load(ls, a, u);
      drive(rd, wr, am, a, d, ls, ss, u);
      if (wr && !bad(ss, a)) model_store(ss, a, d);
      check($sformatf("rnd%0d_rvalid", i), 32'(rvalid), 32'(erv));
      check($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
      check($sformatf("rnd%0d_readdata", i), readdata, exp_rd);
    end

    // Reset in RUN with a load in flight, then reset mid-CLEAR
    memread = 1'b1; daddr = 32'h8; lwhb = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; memread = 1'b0;
    model_clear();
    check("runrst_rvalid", 32'(rvalid), 0);
    check("runrst_busy", 32'(busy), 1);
    check("runrst_readdata", readdata, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy(n);
    check("reclear_len", 32'(n), 16);
    drive(1, 0, 4'h0, 32'h8, 0, 2'b00, 2'b00, 0);
    check("reclear_rvalid", 32'(rvalid), 1);
    check("reclear_data", readdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
